// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid-register stage.
package pipe_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_FULL  = ST_FULL,
        S_SKID  = ST_SKID
    } state_t;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Ready/valid handshake bundle for one pipeline stage (upstream + downstream sides).
interface pipe_skid_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dff_en_vec.sv
// Vector register: async active-low reset, synchronous clear (priority) and load enable.
module dff_en_vec #(
    parameter int unsigned           WIDTH   = 32,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= RST_VAL;
        else if (clr) q <= RST_VAL;
        else if (en)  q <= d;
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a one-entry skid buffer; in_ready comes from a flop, not from out_ready.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic            clk,
    input logic            rst_n,
    pipe_skid_reg_if.slave bus
);

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             acc, pop;
    logic             load_main, load_skid, sel_skid;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    assign acc = bus.in_valid & in_ready_q;
    assign pop = out_valid_q & bus.out_ready;

    // State and handshake flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state and data-load strobes; flush overrides every handshake
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        sel_skid  = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (acc) begin
                    state_d   = S_FULL;
                    load_main = 1'b1;
                end
            end
            S_FULL: begin
                if (acc && !pop) begin
                    state_d   = S_SKID;
                    load_skid = 1'b1;
                end else if (acc && pop) begin
                    load_main = 1'b1;
                end else if (pop) begin
                    state_d   = S_EMPTY;
                end
            end
            S_SKID: begin
                if (pop) begin
                    state_d   = S_FULL;
                    load_main = 1'b1;
                    sel_skid  = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (bus.flush) begin
            state_d   = S_EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
        in_ready_d  = (state_d != S_SKID);
        out_valid_d = (state_d != S_EMPTY);
    end

    assign main_d = sel_skid ? skid_q : bus.in_data;

    dff_en_vec #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.flush),
        .en    (load_main),
        .d     (main_d),
        .q     (main_q)
    );

    dff_en_vec #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.flush),
        .en    (load_skid),
        .d     (bus.in_data),
        .q     (skid_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, reset corners, and random traffic against a queue model.
module tb_pipe_skid_reg;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    pipe_skid_reg_if #(.WIDTH(32)) bus ();

    pipe_skid_reg #(.WIDTH(32), .RST_VAL(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ir;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy, input logic fl,
                                input logic e_ov, input logic [31:0] e_od, input logic e_ir);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic check_outs(input string tag, input logic ov, input logic [31:0] od, input logic ir);
        check($sformatf("%s out_valid", tag), 32'(bus.out_valid), 32'(ov));
        check($sformatf("%s out_data", tag), bus.out_data, od);
        check($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'(ir));
    endtask

    logic [31:0] mq[$];
    logic [31:0] last;
    logic        pend;
    logic [31:0] pend_data;
    logic        m_acc, m_pop;
    int          dut_pops, model_pops;

    initial begin
        // streaming
        tbl[0]  = mk(1, 32'h11, 1, 0, 1, 32'h11, 1);
        tbl[1]  = mk(1, 32'h22, 1, 0, 1, 32'h22, 1);
        tbl[2]  = mk(1, 32'h33, 1, 0, 1, 32'h33, 1);
        tbl[3]  = mk(0, 32'h0,  1, 0, 0, 32'h33, 1);
        // fill skid
        tbl[4]  = mk(1, 32'hA0, 0, 0, 1, 32'hA0, 1);
        tbl[5]  = mk(1, 32'hA1, 0, 0, 1, 32'hA0, 0);
        // ignored while in_ready low
        tbl[6]  = mk(1, 32'hFF, 0, 0, 1, 32'hA0, 0);
        tbl[7]  = mk(1, 32'hFF, 0, 0, 1, 32'hA0, 0);
        tbl[8]  = mk(1, 32'hFF, 0, 0, 1, 32'hA0, 0);
        tbl[9]  = mk(1, 32'hFF, 0, 0, 1, 32'hA0, 0);
        // drain
        tbl[10] = mk(0, 32'h0,  1, 0, 1, 32'hA1, 1);
        tbl[11] = mk(0, 32'h0,  1, 0, 0, 32'hA1, 1);
        // flush from SKID with a colliding accept
        tbl[12] = mk(1, 32'hA0, 0, 0, 1, 32'hA0, 1);
        tbl[13] = mk(1, 32'hA1, 0, 0, 1, 32'hA0, 0);
        tbl[14] = mk(1, 32'h55, 1, 1, 0, 32'h0,  1);
        tbl[15] = mk(0, 32'h0,  1, 0, 0, 32'h0,  1);
        // flush from FULL drops the accepted entry
        tbl[16] = mk(1, 32'h66, 0, 0, 1, 32'h66, 1);
        tbl[17] = mk(1, 32'h77, 1, 1, 0, 32'h0,  1);
        tbl[18] = mk(0, 32'h0,  1, 0, 0, 32'h0,  1);

        // reset held with in_valid high
        rst_n = 1'b0;
        drive(1, 32'hDEAD, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs($sformatf("rst%0d", i), 0, 32'h0, 1);
        end
        #2;
        rst_n = 1'b1;
        drive(0, 32'h0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
            step();
            check_outs($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_od, tbl[i].e_ir);
        end

        // async reset mid-transfer, released mid-cycle
        drive(1, 32'h99, 0, 0);
        step();
        check_outs("preasync", 1, 32'h99, 1);
        drive(1, 32'h9A, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async", 0, 32'h0, 1);
        #2;
        drive(1, 32'hBB, 0, 0);
        rst_n = 1'b1;
        step();
        check_outs("postrel", 1, 32'hBB, 1);

        // resync with a flush, then random traffic
        drive(0, 32'h0, 1, 1);
        step();
        check_outs("sync", 0, 32'h0, 1);
        last = 32'h0;
        pend = 1'b0;
        pend_data = 32'h0;
        dut_pops = 0;
        model_pops = 0;
        for (int c = 0; c < 10000; c++) begin
            logic iv, ordy, fl;
            logic [31:0] d;
            fl   = ($urandom_range(31) == 0);
            ordy = ($urandom_range(9) < 6);
            if (pend) begin
                iv = 1'b1;
                d  = pend_data;
            end else begin
                iv = ($urandom_range(9) < 7);
                d  = $urandom;
            end
            if (iv) drive(1, d, ordy, fl);
            else    drive(0, 'x, ordy, fl);

            if (bus.out_valid && bus.out_ready && !fl) dut_pops++;
            m_acc = iv && (mq.size() < 2);
            m_pop = (mq.size() > 0) && ordy;
            if (fl) begin
                mq.delete();
                last = 32'h0;
            end else begin
                if (m_pop) begin
                    void'(mq.pop_front());
                    model_pops++;
                end
                if (m_acc) mq.push_back(d);
                if (mq.size() > 0) last = mq[0];
            end
            pend      = iv && !m_acc && !fl;
            pend_data = d;

            step();
            check_outs($sformatf("rnd%0d", c), (mq.size() > 0), last, (mq.size() < 2));
        end
        check("pop count", 32'(dut_pops), 32'(model_pops));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
